demux_1to4_sched: RTL and testbench
===================================

# demux_1to4_sched

Sequencing controller for the 32-bit 1-to-4 demultiplexer datapath. It accepts a valid/ready word stream, selects one of four destination channels (directed by a per-word destination or by strict round-robin), and holds the word in a one-entry output register. It presents the word only on the selected channel until that channel's ready completes the transfer, and keeps per-channel transfer counters. It sits between a single producer and four consumers in place of a free-running `sel`.

## Interface
- `width`, 32: data word width.
- `cnt_width`, 8: width of each per-channel transfer counter.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `mode`  input  1  0 = directed (use `dest`), 1 = round-robin.
- `i`  input  width  input data word.
- `dest`  input  2  destination channel for directed mode.
- `i_valid`  input  1  input word valid.
- `i_ready`  output  1  block can accept a word this cycle.
- `o0`, `o1`, `o2`, `o3`  output  width  channel data; only the selected channel carries the word, the others are 0.
- `o_valid`  output  4  one-hot valid per channel; 0 when the block is empty.
- `o_ready`  input  4  per-channel consumer ready.
- `sel`  output  2  channel of the held word; holds its last value when empty.
- `rr_ptr`  output  2  next round-robin channel.
- `cnt`  output  4*cnt_width  packed counters, channel k at `[k*cnt_width +: cnt_width]`.

## Operation
- State machine:
  - Two states, EMPTY and FULL, stored as the holding-register valid bit.
  - EMPTY to FULL on accept.
  - FULL to EMPTY on drain without a new accept.
  - FULL to FULL on drain with a simultaneous accept.
- Accept: `i_valid & i_ready`. Data is captured into the holding register.
- Destination is resolved at accept time:
  - `mode` = 0: target = `dest`.
  - `mode` = 1: target = `rr_ptr`.
  - The target is registered into `sel`.
- Drain: FULL and `o_ready[sel]` = 1. Ready on non-selected channels is ignored.
- `i_ready` = EMPTY | drain. Back-to-back words therefore move at one word per cycle when consumers are ready.
- Round-robin pointer:
  - `rr_ptr` increments modulo 4 (3 wraps to 0) on every accept made in mode 1.
  - Accepts in mode 0 leave `rr_ptr` unchanged.
  - Round-robin is strict: it never skips a busy channel. A stalled channel blocks the stream.
- `mode` and `dest` are sampled only on accept. Changing them while FULL does not retarget the held word.
- Counter k increments by 1 on each drain to channel k. It wraps from 2^cnt_width−1 to 0.
- Output data:
  - `o[sel]` = held word while FULL.
  - All `o*` = 0 while EMPTY.
  - Non-selected outputs are always 0.
  - Outputs are driven combinationally from registered state only. There is no combinational path from `i` to `o*`.

## Timing
- Latency: a word accepted at edge N appears on `o[sel]` with `o_valid[sel]` = 1 after edge N. It stays until the edge where `o_ready[sel]` is sampled high.
- `i_ready` combinationally depends on `o_ready` (drain pass-through). There is no dependence on `i_valid`.
- Simultaneous drain and accept at edge N: the old word completes and its counter increments. The new word is held and `sel` is updated. `o_valid` stays asserted, possibly moving to a different channel.
- Reset, which takes effect even mid-transfer:
  - State becomes EMPTY. `o_valid` = 0 and all `o*` = 0.
  - `sel` = 0, `rr_ptr` = 0, all counters = 0, `i_ready` = 1 in the cycle after reset.
  - A held word is discarded and not counted.
- When `rst` is high at an edge, `i_valid`, `i`, and `o_ready` are ignored at that edge.

## Test plan
- **Reset.** Assert `rst` for 2 cycles with `i_valid` = 1 → `o_valid` = 0, `o0`..`o3` = 0, `sel` = 0, `rr_ptr` = 0, `cnt` = 0, `i_ready` = 1 after release.
- **Directed mode.** `mode` = 0, `o_ready` = 4'hF. Send `i` = 32'hA000_0000/`dest` 0, 32'hB000_0000/1, 32'hC000_0000/2, 32'hD000_0000/3 on consecutive cycles → each word appears one cycle later on `o0`, `o1`, `o2`, `o3` respectively, the others read 0. `i_ready` stays 1 throughout. Each counter = 1.
- **Round-robin wrap.** `mode` = 1. Send 6 words 1..6 → targets 0,1,2,3,0,1. `rr_ptr` ends at 2. `cnt` = {8'd1,8'd1,8'd2,8'd2} (channel 3..0).
- **Backpressure.** `mode` = 0, `dest` = 2, `o_ready[2]` = 0 for 5 cycles, `o_ready` for other channels = 1 → `o2` holds the word and `i_ready` = 0 for all 5 cycles. Toggling `dest` or `mode` has no effect. Raising `o_ready[2]` drains on that edge and `i_ready` = 1 in the same cycle.
- **Simultaneous drain and accept.** Channel 1 is FULL. `o_ready[1]` = 1 and a new word 32'h1234_5678 with `dest` 3 arrives in the same cycle → the next cycle shows `o_valid` = 4'b1000, `o3` = 32'h1234_5678, `o1` = 0, cnt1 incremented.
- **Reset mid-transfer and counter wrap.** Reset while FULL → `o_valid` = 0 next cycle and no counter change. Then, with `cnt_width` = 8, 256 drains to channel 0 → cnt0 wraps to 0.

Source files
------------

// File: rtl/demux_1to4_sched.sv
// One-entry holding register steering a valid/ready word stream to one of four channels.
// Latency: 1 cycle accept-to-output; i_ready drops while the held word's channel is stalled.
// Backpressure: a stalled selected channel blocks the whole stream (strict round-robin, no skipping).
module demux_1to4_sched #(
    parameter int width     = 32,
    parameter int cnt_width = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mode,
    input  logic [width-1:0]       i,
    input  logic [1:0]             dest,
    input  logic                   i_valid,
    output logic                   i_ready,
    output logic [width-1:0]       o0,
    output logic [width-1:0]       o1,
    output logic [width-1:0]       o2,
    output logic [width-1:0]       o3,
    output logic [3:0]             o_valid,
    input  logic [3:0]             o_ready,
    output logic [1:0]             sel,
    output logic [1:0]             rr_ptr,
    output logic [4*cnt_width-1:0] cnt
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    localparam logic [cnt_width-1:0] CNT_ONE = {{(cnt_width-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic [width-1:0]       data_q, data_d;
    logic [1:0]             sel_q, sel_d;
    logic [1:0]             rr_q, rr_d;
    logic [4*cnt_width-1:0] cnt_q, cnt_d;
    logic                   accept;
    logic                   drain;

    // Ready on channels other than the held word's is deliberately ignored.
    assign drain   = (state_q == FULL) && o_ready[sel_q];
    assign i_ready = (state_q == EMPTY) || drain;
    assign accept  = i_valid && i_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            sel_q   <= 2'd0;
            rr_q    <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (drain && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Destination and mode are sampled only at accept, so a held word never retargets.
    always_comb begin
        data_d = data_q;
        sel_d  = sel_q;
        rr_d   = rr_q;
        cnt_d  = cnt_q;
        if (accept) begin
            data_d = i;
            sel_d  = mode ? rr_q : dest;
            if (mode) rr_d = rr_q + 2'd1;
        end
        for (int k = 0; k < 4; k++) begin
            if (drain && (sel_q == 2'(k)))
                cnt_d[k*cnt_width +: cnt_width] = cnt_q[k*cnt_width +: cnt_width] + CNT_ONE;
        end
    end

    always_comb begin
        o_valid = 4'b0000;
        if (state_q == FULL) o_valid[sel_q] = 1'b1;
        o0     = o_valid[0] ? data_q : '0;
        o1     = o_valid[1] ? data_q : '0;
        o2     = o_valid[2] ? data_q : '0;
        o3     = o_valid[3] ? data_q : '0;
        sel    = sel_q;
        rr_ptr = rr_q;
        cnt    = cnt_q;
    end

endmodule

// File: tb/tb_demux_1to4_sched.sv
// Randomized and directed bench: transaction-level model plus scoreboard of words in delivery order.
module tb_demux_1to4_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [31:0] i;
    logic [1:0]  dest;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] o0, o1, o2, o3;
    logic [3:0]  o_valid;
    logic [3:0]  o_ready;
    logic [1:0]  sel;
    logic [1:0]  rr_ptr;
    logic [31:0] cnt;

    demux_1to4_sched #(.width(32), .cnt_width(8)) dut (
        .clk(clk), .rst(rst), .mode(mode), .i(i), .dest(dest),
        .i_valid(i_valid), .i_ready(i_ready),
        .o0(o0), .o1(o1), .o2(o2), .o3(o3),
        .o_valid(o_valid), .o_ready(o_ready),
        .sel(sel), .rr_ptr(rr_ptr), .cnt(cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ch;
        logic [31:0] d;
    } xfer_t;

    xfer_t       sb[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    bit          started = 0;

    // Abstract model: a one-word buffer, its destination, a 0..3 round-robin pointer, four byte counters.
    bit          m_full;
    logic [1:0]  m_sel;
    logic [1:0]  m_rr;
    logic [7:0]  m_cnt[4];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_cnt();
        return {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]};
    endfunction

    task automatic model_reset();
        m_full = 0;
        m_sel  = 2'd0;
        m_rr   = 2'd0;
        for (int k = 0; k < 4; k++) m_cnt[k] = 8'd0;
        sb.delete();
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        i_valid = 1'b1;
        i       = $urandom;
        o_ready = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        i_valid = 1'b0;
        model_reset();
    endtask

    // One clock of stimulus; predicts handshake from the model and checks visible state at negedge.
    task automatic cyc(input logic v, input logic [31:0] d, input logic [1:0] dst,
                       input logic md, input logic [3:0] ordy);
        logic       drn, rdy, acc;
        logic [1:0] tgt;
        i_valid = v;
        i       = d;
        dest    = dst;
        mode    = md;
        o_ready = ordy;
        @(negedge clk);
        drn = m_full && ordy[m_sel];
        rdy = !m_full || drn;
        check("i_ready", {31'd0, i_ready}, {31'd0, rdy});
        check("o_valid", {28'd0, o_valid}, m_full ? (32'd1 << m_sel) : 32'd0);
        check("sel", {30'd0, sel}, {30'd0, m_sel});
        check("rr_ptr", {30'd0, rr_ptr}, {30'd0, m_rr});
        check("cnt", cnt, exp_cnt());
        acc = v && rdy;
        if (drn) m_cnt[m_sel] = m_cnt[m_sel] + 8'd1;
        if (acc) begin
            tgt = md ? m_rr : dst;
            sb.push_back('{tgt, d});
            m_sel = tgt;
            if (md) m_rr = m_rr + 2'd1;
        end
        m_full = acc || (m_full && !drn);
        @(posedge clk);
        #1;
    endtask

    // Monitor: whenever a word is presented and its channel is ready, it must be the oldest expected word.
    logic [31:0] mon_o[4];
    int          mon_ch;
    xfer_t       mon_x;
    always @(negedge clk) begin
        if (started && !rst) begin
            mon_o[0] = o0; mon_o[1] = o1; mon_o[2] = o2; mon_o[3] = o3;
            if (o_valid == 4'd0) begin
                check("idle_outputs_zero", o0 | o1 | o2 | o3, 32'd0);
            end else begin
                mon_ch = 0;
                for (int k = 3; k >= 0; k--) if (o_valid[k]) mon_ch = k;
                check("o_valid_onehot", {28'd0, o_valid}, 32'd1 << mon_ch);
                for (int k = 0; k < 4; k++)
                    if (k != mon_ch) check("unselected_zero", mon_o[k], 32'd0);
                if (o_ready[mon_ch]) begin
                    if (sb.size() == 0) begin
                        check("unexpected_drain", 32'd1, 32'd0);
                    end else begin
                        mon_x = sb.pop_front();
                        check("drain_channel", mon_ch, {30'd0, mon_x.ch});
                        check("drain_data", mon_o[mon_ch], mon_x.d);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; mode = 1'b0; i = '0; dest = '0; i_valid = 1'b0; o_ready = 4'h0;
        do_reset();
        started = 1;
        check("reset_cnt", cnt, 32'd0);
        check("reset_o_valid", {28'd0, o_valid}, 32'd0);
        check("reset_i_ready", {31'd0, i_ready}, 32'd1);

        // Directed, one word per channel back to back.
        cyc(1, 32'hA000_0000, 2'd0, 0, 4'hF);
        cyc(1, 32'hB000_0000, 2'd1, 0, 4'hF);
        cyc(1, 32'hC000_0000, 2'd2, 0, 4'hF);
        cyc(1, 32'hD000_0000, 2'd3, 0, 4'hF);
        cyc(0, 32'd0, 2'd0, 0, 4'hF);
        check("directed_cnt", cnt, 32'h0101_0101);

        // Round-robin wrap from a fresh state.
        do_reset();
        for (int k = 1; k <= 6; k++) cyc(1, k, 2'($urandom), 1, 4'hF);
        cyc(0, 32'd0, 2'd0, 1, 4'hF);
        check("rr_ptr_end", {30'd0, rr_ptr}, 32'd2);
        check("rr_cnt", cnt, 32'h0101_0202);

        // Backpressure on channel 2 while dest/mode wiggle.
        cyc(1, 32'h5555_AAAA, 2'd2, 0, 4'hF);
        for (int k = 0; k < 5; k++) cyc(1, $urandom, 2'($urandom), 1'($urandom), 4'b1011);
        check("bp_o2_held", o2, 32'h5555_AAAA);
        cyc(0, 32'd0, 2'd0, 0, 4'hF);
        cyc(0, 32'd0, 2'd0, 0, 4'hF);

        // Simultaneous drain of channel 1 and accept into channel 3.
        cyc(1, 32'h0BAD_F00D, 2'd1, 0, 4'h0);
        cyc(1, 32'h1234_5678, 2'd3, 0, 4'b0010);
        check("swap_o3", o3, 32'h1234_5678);
        check("swap_o1", o1, 32'd0);
        check("swap_o_valid", {28'd0, o_valid}, 32'h8);
        cyc(0, 32'd0, 2'd0, 0, 4'h0);
        cyc(0, 32'd0, 2'd0, 0, 4'hF);

        // Reset while holding a word, then counter wrap on channel 0.
        cyc(1, 32'hDEAD_BEEF, 2'd2, 0, 4'h0);
        do_reset();
        check("midreset_o_valid", {28'd0, o_valid}, 32'd0);
        check("midreset_cnt", cnt, 32'd0);
        for (int k = 0; k < 256; k++) cyc(1, $urandom, 2'd0, 0, 4'hF);
        cyc(0, 32'd0, 2'd0, 0, 4'hF);
        check("cnt0_wrap", cnt, 32'd0);

        // Random traffic with occasional resets.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            cyc(1'($urandom_range(0, 1)), $urandom, 2'($urandom), 1'($urandom),
                4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
